// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 9-bit-ISA core.
// Owns the PC, gates register/memory write strobes and counts busy cycles.
//
// Ports:
//   clk, rst_n      clock and async active-low reset
//   start           begin execution at PC 0 (honoured in IDLE/HALT)
//   dec_*           decoder flags and jump immediate, valid from EXEC on
//   alu_zero        branch compare result
//   mem_ack         data memory access complete
//   pc              instruction ROM address
//   ir_load         instruction register capture (DECODE)
//   reg_we          gated register-file write enable (WB)
//   mem_req/mem_we  data memory request and write qualifier (MEM)
//   busy/done       running / halted status
//   cycle_count     saturating count of running cycles since start
module cpu_sequencer #(
  parameter int PC_WIDTH  = 10,
  parameter int IMM_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dec_jump,
  input  logic                 dec_halt,
  input  logic                 dec_is_branch,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_reg_write,
  input  logic [IMM_WIDTH-1:0] dec_imm,
  input  logic                 alu_zero,
  input  logic                 mem_ack,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 ir_load,
  output logic                 reg_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam int EW = (PC_WIDTH > IMM_WIDTH) ? PC_WIDTH : IMM_WIDTH;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [EW-1:0]        imm_ext;
  logic [PC_WIDTH-1:0]  jmp_tgt;
  logic                 run;

  // Zero-extend or truncate the immediate to the PC width.
  assign imm_ext = EW'(dec_imm);
  assign jmp_tgt = imm_ext[PC_WIDTH-1:0];

  assign run = (state_q == S_FETCH) || (state_q == S_DECODE) ||
               (state_q == S_EXEC)  || (state_q == S_MEM) ||
               (state_q == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    // Saturate rather than wrap.
    if (run && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_jump) begin
          pc_d    = jmp_tgt;
          state_d = S_FETCH;
        end else if (dec_is_branch) begin
          pc_d    = alu_zero ? pc_q + PC_WIDTH'(2)
                             : pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          // Read+write together is treated as a store.
          if (dec_mem_write) begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign cycle_count = cnt_q;
  assign busy        = run;
  assign done        = (state_q == S_HALT);
  assign ir_load     = (state_q == S_DECODE);
  assign mem_req     = (state_q == S_MEM);
  assign mem_we      = (state_q == S_MEM) && dec_mem_write;
  assign reg_we      = (state_q == S_WB) && dec_reg_write &&
                       !dec_mem_write;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer.
// Expected results are queued at stimulus time and popped at compare.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dec_jump, dec_halt, dec_is_branch;
  logic        dec_mem_read, dec_mem_write, dec_reg_write;
  logic [7:0]  dec_imm;
  logic        alu_zero, mem_ack;
  logic [9:0]  pc;
  logic        ir_load, reg_we, mem_req, mem_we, busy, done;
  logic [15:0] cycle_count;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dec_jump(dec_jump), .dec_halt(dec_halt),
    .dec_is_branch(dec_is_branch),
    .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write),
    .dec_imm(dec_imm), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .pc(pc), .ir_load(ir_load),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nfail = 0;
  int   m_pc = 0;
  int   m_cnt = 0;

  task automatic push(input string t, input int v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    nvec++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty: got %0d required nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nfail++;
        $error("FAIL %s: got %0h required %0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clr_dec();
    dec_jump = 0; dec_halt = 0; dec_is_branch = 0;
    dec_mem_read = 0; dec_mem_write = 0;
    dec_reg_write = 0; dec_imm = '0;
    alu_zero = 0; mem_ack = 0; start = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE/HALT; leaves DUT in FETCH at pc 0.
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    m_pc = 0;
    m_cnt = 0;
    push("start_pc", 0);
    push("start_cnt", 0);
    push("start_done", 0);
    push("start_busy", 1);
    chk(32'(pc));
    chk(32'(cycle_count));
    chk(32'(done));
    chk(32'(busy));
  endtask

  // Runs one instruction from FETCH. junk drives start and
  // mem_ack high outside MEM to show they are ignored.
  task automatic do_instr(
    input logic j, input logic h, input logic br,
    input logic mr, input logic mw, input logic rw,
    input logic [7:0] imm, input logic z,
    input int waitn, input logic junk);
    int lat, xrw, xmq, xmw, npc;
    int il, rwc, mqc, mwc, bl;
    dec_jump = j; dec_halt = h; dec_is_branch = br;
    dec_mem_read = mr; dec_mem_write = mw;
    dec_reg_write = rw; dec_imm = imm; alu_zero = z;
    xrw = 0; xmq = 0; xmw = 0;
    if (h) begin
      lat = 3; npc = m_pc;
    end else if (j) begin
      lat = 3; npc = int'(imm);
    end else if (br) begin
      lat = 3; npc = (m_pc + (z ? 2 : 1)) % 1024;
    end else if (mr || mw) begin
      xmq = waitn + 1;
      npc = (m_pc + 1) % 1024;
      if (mw) begin
        lat = 4 + waitn; xmw = xmq;
      end else begin
        lat = 5 + waitn; xrw = rw;
      end
    end else begin
      lat = 4; xrw = rw; npc = (m_pc + 1) % 1024;
    end
    m_pc = npc;
    m_cnt = m_cnt + lat;
    push("pc", npc);
    push("reg_we_pulses", xrw);
    push("mem_req_cycles", xmq);
    push("mem_we_cycles", xmw);
    push("ir_load_pulses", 1);
    push("busy_low_cycles", 0);
    push("done", h);
    push("busy_after", !h);
    push("cycle_count", m_cnt);
    il = 0; rwc = 0; mqc = 0; mwc = 0; bl = 0;
    start = junk;
    for (int k = 0; k < lat; k++) begin
      il += int'(ir_load);
      rwc += int'(reg_we);
      bl += int'(!busy);
      if (mem_req) begin
        mqc++;
        mwc += int'(mem_we);
        mem_ack = (mqc == waitn + 1);
      end else begin
        mem_ack = junk;
      end
      tick();
    end
    mem_ack = 0;
    start = 0;
    chk(32'(pc));
    chk(32'(rwc));
    chk(32'(mqc));
    chk(32'(mwc));
    chk(32'(il));
    chk(32'(bl));
    chk(32'(done));
    chk(32'(busy));
    chk(32'(cycle_count));
  endtask

  initial begin
    rst_n = 0;
    clr_dec();
    tick();
    tick();
    push("rst_pc", 0);
    push("rst_cnt", 0);
    push("rst_busy", 0);
    push("rst_done", 0);
    push("rst_mem_req", 0);
    chk(32'(pc));
    chk(32'(cycle_count));
    chk(32'(busy));
    chk(32'(done));
    chk(32'(mem_req));
    rst_n = 1;
    tick();
    tick();
    push("idle_busy", 0);
    chk(32'(busy));

    do_start();
    // ALU op with register write
    do_instr(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    // branch at pc 5, taken and not taken
    do_instr(1, 0, 0, 0, 0, 0, 8'h05, 0, 0, 0);
    do_instr(0, 0, 1, 0, 0, 1, 8'h00, 1, 0, 0);
    do_instr(1, 0, 0, 0, 0, 0, 8'h05, 0, 0, 0);
    do_instr(0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 0);
    // jump to 0x2A
    do_instr(1, 0, 0, 0, 0, 0, 8'h2A, 0, 0, 0);
    // load with 3 wait cycles
    do_instr(0, 0, 0, 1, 0, 1, 8'h00, 0, 3, 0);
    // store with reg_write also set
    do_instr(0, 0, 0, 0, 1, 1, 8'h00, 0, 2, 0);
    // read+write flagged together behaves as store
    do_instr(0, 0, 0, 1, 1, 1, 8'h00, 0, 0, 0);
    // start and stray mem_ack while busy are ignored
    do_instr(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 1);
    // walk pc to 0x3FF, then wrap via WB
    do_instr(1, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 384; i++)
      do_instr(0, 0, 1, 0, 0, 0, 8'h00, 1, 0, 0);
    do_instr(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    // jump+halt -> halt wins, pc kept
    do_instr(1, 1, 0, 0, 0, 0, 8'h10, 0, 0, 0);
    tick();
    tick();
    push("halt_cnt_hold", m_cnt);
    push("halt_done_hold", 1);
    chk(32'(cycle_count));
    chk(32'(done));

    // restart from HALT
    do_start();
    do_instr(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0);

    // reset while waiting in MEM
    dec_mem_read = 1;
    dec_mem_write = 0;
    dec_reg_write = 1;
    tick();
    tick();
    tick();
    tick();
    push("mem_wait_req", 1);
    chk(32'(mem_req));
    #2;
    rst_n = 0;
    #1;
    push("rst_mid_mem_req", 0);
    push("rst_mid_busy", 0);
    push("rst_mid_pc", 0);
    push("rst_mid_cnt", 0);
    chk(32'(mem_req));
    chk(32'(busy));
    chk(32'(pc));
    chk(32'(cycle_count));
    tick();
    rst_n = 1;
    tick();
    tick();
    push("post_rst_busy", 0);
    push("post_rst_done", 0);
    chk(32'(busy));
    chk(32'(done));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
